dc1_tag_sched: RTL and testbench
================================

# dc1_tag_sched

Arbitrates access to the eight L1 data-cache tag ways between three requesters: load lookups, line fills and snoop invalidations. It sequences the tag array's post-reset init window, drives the shared read/write/invalidate controls of all ways, and generates the victim-select random vector. It sits between the load pipe, miss unit and coherence unit on one side and the `dcache1_tag` instances on the other.

## Interface
- `INV_DEPTH`, 8, snoop-invalidate queue entries (power of 2, ≥6).
- `INIT_CYCLES`, 64, cycles the tag ways spend self-initialising after reset.

Ports:
- `clk` in 1: clock. All state updates on the falling edge, matching the tag ways.
- `rst` in 1: reset, synchronous, active-high.
- `ld_req` in 1: load lookup request.
- `ld_addrOdd`, `ld_addrEven` in 36 each: lookup physical addresses, bits [43:8].
- `ld_odd` in 1: load odd-bank select.
- `ld_split` in 1: load split select.
- `ld_gnt` out 1: load accepted this cycle.
- `fill_req` in 1: fill request.
- `fill_addr` in 36: fill physical address [43:8]; bit 0 selects the odd bank.
- `fill_excl` in 1: fill in exclusive state.
- `fill_gnt` out 1: fill accepted.
- `snp_req` in 1: snoop invalidate request.
- `snp_idx` in 7: bank bit [6] plus set [5:0].
- `snp_rdy` out 1: queue can accept.
- `tag_read_clkEn`, `tag_read_en`, `tag_odd`, `tag_split`, `tag_invl` out 1 each: to all ways.
- `tag_addrOdd`, `tag_addrEven` out 36 each: to all ways.
- `tag_write_wen`, `tag_write_exclusive` out 1 each: to all ways.
- `tag_write_rand` out 6: victim random vector.
- `way_recent` in 8: `write_recent_out` of ways 0..7.
- `tag_recent_in` out 1: to all ways' `write_recent_in`.
- `puke_en` out 6: invalidate-port enables.
- `puke_addr` out 6×7: flat invalidate-port indices, port k at bits [7k+6:7k].
- `busy_init` out 1: high during init.

## Operation
- **FSM states:** INIT, IDLE, FILL_TURN.
- **INIT**
  - Entered on `rst`. A counter runs 0..INIT_CYCLES-1.
  - `busy_init=1`; all grants are 0; `snp_rdy` is 0.
  - Leaves to IDLE after the counter reaches INIT_CYCLES-1.
- **IDLE priority:** fill, then load. At most one of `fill_gnt` and `ld_gnt` is high in any cycle.
- **Fill grant**
  - Conditions: `fill_req`, and no queued or incoming snoop with an index equal to `{fill_addr[0], fill_addr[6:1]}`.
  - Drives `tag_read_clkEn=1`, `tag_read_en=1`, `tag_write_wen=1`, `tag_odd=fill_addr[0]`.
  - `tag_addrOdd` and `tag_addrEven` both equal `fill_addr`; `tag_write_exclusive=fill_excl`.
  - Advances the LFSR. Next state is FILL_TURN.
- **FILL_TURN:** one cycle with no load or fill grant, which covers the tag writeback slot. Next state is IDLE.
- **Load grant**
  - Conditions: `ld_req`, no fill granted, and no queued snoop matching `{ld_odd, ld_addr*[5:0]}` of the accessed bank.
  - Drives `tag_read_clkEn=1`, `tag_read_en=1`, and passes the `ld_*` fields straight through.
- **Idle cycles:** `tag_read_clkEn=0`, `tag_read_en=0`, `tag_write_wen=0`.
- **`tag_invl`** is always 0; snoop invalidation uses the puke ports only.
- **LFSR:** 6 bits, polynomial x^6+x^5+1, shift-left, feedback = bit5 XOR bit4. Reset seed is 6'b000001. `tag_write_rand` is the current value.
- **`tag_recent_in`** = `|way_recent`, combinational.
- **Snoop queue**
  - FIFO of INV_DEPTH entries.
  - Push when `snp_req & snp_rdy`.
  - `snp_rdy` = free entries ≥ 1, counted after this cycle's pops.
  - Pops up to 6 oldest entries per cycle; entry i of the pop goes to port i.
  - Unused ports have `puke_en=0` and `puke_addr=0`.
  - No pops during INIT or in a fill-grant cycle.
- **Pointers:** read and write pointers are log2(INV_DEPTH)+1 bits and wrap modulo 2×INV_DEPTH. Full when the MSBs differ and the rest are equal.
- **Simultaneous push and pop:** allowed when full.
- **Reset mid-operation:** flushes the queue, forces INIT, reseeds the LFSR, and drops all outputs to 0 on the next edge.

## Timing
- **Reset values:** all outputs 0, except `busy_init=1`.
- **Combinational paths:** grants and tag control outputs are combinational from requests and registered state, with zero-cycle latency to the tag ways.
- **Snoop latency:** a snoop pushed at edge N reaches the puke ports no earlier than the cycle after N. Queue contents affect hazard checks from the cycle after the push.
- **Fill throughput:** at most one fill per 2 cycles.
- **Load throughput:** one load per cycle when no fill or hazard is present.

## Test plan
- **Init:** `rst` for 1 cycle, `ld_req=1` held → `ld_gnt=0` for 64 cycles, `busy_init` falls, `ld_gnt=1` on cycle 65.
- **Fill/load priority:** `fill_req` and `ld_req` both high from IDLE → `fill_gnt=1`, `tag_write_wen=1`; next cycle both grants 0; the cycle after that `ld_gnt=1`.
- **LFSR sequence:** 3 back-to-back fills after reset → `tag_write_rand` = 01, 02, 04 (hex) on the three grant cycles.
- **Snoop burst:** 8 snoops with indices 0..7, one per cycle → `snp_rdy` stays 1; `puke_en` pops in order; none lost; queue empty within 2 cycles of the last push.
- **Fill hazard:** queue holds idx 0x45, `fill_addr` with bank 1 and set 5 → `fill_gnt=0` until 0x45 appears on a puke port; grant in the following cycle.
- **Full queue:** 9 pushes while a fill stream blocks pops → `snp_rdy=0` after 8; reset asserted → queue empty and `puke_en=0` on the next edge.

Source files
------------

// File: rtl/dc1_tag_sched.sv
// L1 data-cache tag-way scheduler: post-reset init window, fill/load arbitration,
// snoop-invalidate queue draining to the six puke ports, and the victim LFSR.
module dc1_tag_sched #(
   parameter int unsigned INV_DEPTH   = 8,
   parameter int unsigned INIT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ld_req,
   input  logic [35:0] ld_addrOdd,
   input  logic [35:0] ld_addrEven,
   input  logic        ld_odd,
   input  logic        ld_split,
   output logic        ld_gnt,
   input  logic        fill_req,
   input  logic [35:0] fill_addr,
   input  logic        fill_excl,
   output logic        fill_gnt,
   input  logic        snp_req,
   input  logic [6:0]  snp_idx,
   output logic        snp_rdy,
   output logic        tag_read_clkEn,
   output logic        tag_read_en,
   output logic        tag_odd,
   output logic        tag_split,
   output logic        tag_invl,
   output logic [35:0] tag_addrOdd,
   output logic [35:0] tag_addrEven,
   output logic        tag_write_wen,
   output logic        tag_write_exclusive,
   output logic [5:0]  tag_write_rand,
   input  logic [7:0]  way_recent,
   output logic        tag_recent_in,
   output logic [5:0]  puke_en,
   output logic [41:0] puke_addr,
   output logic        busy_init
);

   localparam int unsigned AW    = $clog2(INV_DEPTH);
   localparam int unsigned PW    = AW + 1;
   localparam int unsigned CW    = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
   localparam int unsigned NPORT = 6;

   typedef enum logic [1:0] {INIT, IDLE, FILL_TURN} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] init_cnt;
   logic [5:0]    lfsr;
   logic [6:0]    inv_q [INV_DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr, q_cnt, n_pop;
   logic [AW-1:0] scan_slot, pop_slot;
   logic [6:0]    fill_key, ld_key;
   logic          q_full, fill_hz, ld_hz, push;

   assign fill_key = {fill_addr[0], fill_addr[6:1]};
   assign ld_key   = ld_odd ? {1'b1, ld_addrOdd[5:0]} : {1'b0, ld_addrEven[5:0]};
   assign q_cnt    = wr_ptr - rd_ptr;
   assign q_full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   // Entries being popped this cycle still count as hazards until they leave.
   always_comb begin
      scan_slot = '0;
      fill_hz   = snp_req && (snp_idx == fill_key);
      ld_hz     = 1'b0;
      for (int unsigned i = 0; i < INV_DEPTH; i++) begin
         scan_slot = rd_ptr[AW-1:0] + AW'(i);
         if (PW'(i) < q_cnt) begin
            if (inv_q[scan_slot] == fill_key) fill_hz = 1'b1;
            if (inv_q[scan_slot] == ld_key)   ld_hz   = 1'b1;
         end
      end
   end

   assign fill_gnt = (state == IDLE) && fill_req && !fill_hz;
   assign ld_gnt   = (state == IDLE) && !fill_gnt && ld_req && !ld_hz;

   // The FILL_TURN slot carries the tag writeback, so the puke ports stay quiet too.
   always_comb begin
      n_pop = '0;
      if (state == IDLE && !fill_gnt)
         n_pop = (q_cnt > PW'(NPORT)) ? PW'(NPORT) : q_cnt;
   end

   assign snp_rdy = (state != INIT) && !(q_full && n_pop == '0);
   assign push    = snp_req && snp_rdy;

   always_comb begin
      pop_slot  = '0;
      puke_en   = '0;
      puke_addr = '0;
      for (int unsigned k = 0; k < NPORT; k++) begin
         pop_slot = rd_ptr[AW-1:0] + AW'(k);
         if (PW'(k) < n_pop) begin
            puke_en[k]          = 1'b1;
            puke_addr[7*k +: 7] = inv_q[pop_slot];
         end
      end
   end

   always_comb begin
      tag_read_clkEn      = 1'b0;
      tag_read_en         = 1'b0;
      tag_odd             = 1'b0;
      tag_split           = 1'b0;
      tag_addrOdd         = '0;
      tag_addrEven        = '0;
      tag_write_wen       = 1'b0;
      tag_write_exclusive = 1'b0;
      if (fill_gnt) begin
         tag_read_clkEn      = 1'b1;
         tag_read_en         = 1'b1;
         tag_write_wen       = 1'b1;
         tag_odd             = fill_addr[0];
         tag_addrOdd         = fill_addr;
         tag_addrEven        = fill_addr;
         tag_write_exclusive = fill_excl;
      end else if (ld_gnt) begin
         tag_read_clkEn = 1'b1;
         tag_read_en    = 1'b1;
         tag_odd        = ld_odd;
         tag_split      = ld_split;
         tag_addrOdd    = ld_addrOdd;
         tag_addrEven   = ld_addrEven;
      end
   end

   assign tag_invl       = 1'b0;
   assign tag_recent_in  = |way_recent;
   assign busy_init      = (state == INIT);
   assign tag_write_rand = busy_init ? '0 : lfsr;

   always_comb begin
      state_nxt = state;
      case (state)
         INIT:      if (init_cnt == CW'(INIT_CYCLES - 1)) state_nxt = IDLE;
         IDLE:      if (fill_gnt) state_nxt = FILL_TURN;
         FILL_TURN: state_nxt = IDLE;
         default:   state_nxt = INIT;
      endcase
   end

   always_ff @(negedge clk) begin
      if (rst) begin
         state    <= INIT;
         init_cnt <= '0;
         lfsr     <= 6'b000001;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
      end else begin
         state  <= state_nxt;
         rd_ptr <= rd_ptr + n_pop;
         if (state == INIT) init_cnt <= init_cnt + CW'(1);
         if (fill_gnt)      lfsr     <= {lfsr[4:0], lfsr[5] ^ lfsr[4]};
         if (push)          wr_ptr   <= wr_ptr + PW'(1);
      end
   end

   always_ff @(negedge clk) begin
      if (push) inv_q[wr_ptr[AW-1:0]] <= snp_idx;
   end

endmodule

// File: tb/tb_dc1_tag_sched.sv
// Directed bench for dc1_tag_sched; snoop pops are checked against a scoreboard queue.
module tb_dc1_tag_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic        ld_req, ld_odd, ld_split, ld_gnt;
   logic [35:0] ld_addrOdd, ld_addrEven;
   logic        fill_req, fill_excl, fill_gnt;
   logic [35:0] fill_addr;
   logic        snp_req, snp_rdy;
   logic [6:0]  snp_idx;
   logic        tag_read_clkEn, tag_read_en, tag_odd, tag_split, tag_invl;
   logic [35:0] tag_addrOdd, tag_addrEven;
   logic        tag_write_wen, tag_write_exclusive;
   logic [5:0]  tag_write_rand;
   logic [7:0]  way_recent;
   logic        tag_recent_in;
   logic [5:0]  puke_en;
   logic [41:0] puke_addr;
   logic        busy_init;

   int unsigned n_assert = 0;
   int unsigned n_fail   = 0;
   logic [6:0]  sb [$];
   logic [5:0]  m_lfsr;
   logic [5:0]  exp_rand [3];

   always #5 clk = ~clk;

   dc1_tag_sched #(.INV_DEPTH(8), .INIT_CYCLES(64)) dut (
      .clk(clk), .rst(rst),
      .ld_req(ld_req), .ld_addrOdd(ld_addrOdd), .ld_addrEven(ld_addrEven),
      .ld_odd(ld_odd), .ld_split(ld_split), .ld_gnt(ld_gnt),
      .fill_req(fill_req), .fill_addr(fill_addr), .fill_excl(fill_excl), .fill_gnt(fill_gnt),
      .snp_req(snp_req), .snp_idx(snp_idx), .snp_rdy(snp_rdy),
      .tag_read_clkEn(tag_read_clkEn), .tag_read_en(tag_read_en), .tag_odd(tag_odd),
      .tag_split(tag_split), .tag_invl(tag_invl),
      .tag_addrOdd(tag_addrOdd), .tag_addrEven(tag_addrEven),
      .tag_write_wen(tag_write_wen), .tag_write_exclusive(tag_write_exclusive),
      .tag_write_rand(tag_write_rand), .way_recent(way_recent), .tag_recent_in(tag_recent_in),
      .puke_en(puke_en), .puke_addr(puke_addr), .busy_init(busy_init)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Pops up to six oldest scoreboard entries when the cycle may pop.
   task automatic check_puke(input bit pop_ok);
      int unsigned n;
      logic [5:0]  en_exp;
      logic [6:0]  e;
      n = 0;
      if (pop_ok) n = (sb.size() > 6) ? 6 : sb.size();
      en_exp = '0;
      for (int unsigned k = 0; k < 6; k++) if (k < n) en_exp[k] = 1'b1;
      chk("puke_en", puke_en, en_exp);
      for (int unsigned k = 0; k < 6; k++) begin
         e = (k < n) ? sb.pop_front() : 7'h00;
         chk($sformatf("puke_addr%0d", k), puke_addr[7*k +: 7], e);
      end
   endtask

   function automatic logic [5:0] lfsr_step(input logic [5:0] v);
      return {v[4:0], v[5] ^ v[4]};
   endfunction

   task automatic adv;
      @(negedge clk);
      #1;
   endtask

   task automatic smp;
      @(posedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_rand[0] = 6'h01; exp_rand[1] = 6'h02; exp_rand[2] = 6'h04;
      rst = 1'b1; ld_req = 1'b0; ld_odd = 1'b0; ld_split = 1'b0;
      ld_addrOdd = '0; ld_addrEven = '0;
      fill_req = 1'b0; fill_excl = 1'b0; fill_addr = '0;
      snp_req = 1'b0; snp_idx = '0; way_recent = '0;
      m_lfsr = 6'h01;

      // reset state
      adv;
      smp;
      chk("rst_busy_init", busy_init, 1);
      chk("rst_ld_gnt", ld_gnt, 0);
      chk("rst_fill_gnt", fill_gnt, 0);
      chk("rst_snp_rdy", snp_rdy, 0);
      chk("rst_puke_en", puke_en, 0);
      chk("rst_tag_read_en", tag_read_en, 0);
      chk("rst_tag_write_wen", tag_write_wen, 0);
      adv;

      // init window with a load held pending
      rst = 1'b0; ld_req = 1'b1; ld_odd = 1'b1; ld_split = 1'b1;
      ld_addrOdd = 36'h987654321; ld_addrEven = 36'h123456789;
      for (int i = 0; i < 64; i++) begin
         smp;
         chk($sformatf("init_ld_gnt_c%0d", i), ld_gnt, 0);
         chk($sformatf("init_busy_c%0d", i), busy_init, 1);
         adv;
      end
      smp;
      chk("idle_busy_init", busy_init, 0);
      chk("idle_ld_gnt", ld_gnt, 1);
      chk("ld_read_en", tag_read_en, 1);
      chk("ld_read_clkEn", tag_read_clkEn, 1);
      chk("ld_addrOdd", tag_addrOdd, 36'h987654321);
      chk("ld_addrEven", tag_addrEven, 36'h123456789);
      chk("ld_tag_odd", tag_odd, 1);
      chk("ld_tag_split", tag_split, 1);
      chk("ld_wen", tag_write_wen, 0);
      chk("idle_snp_rdy", snp_rdy, 1);
      chk("tag_invl", tag_invl, 0);
      check_puke(1);
      adv;

      // fill beats load; turnaround cycle; then load
      fill_req = 1'b1; fill_excl = 1'b1; fill_addr = 36'h0000000F3;
      smp;
      chk("prio_fill_gnt", fill_gnt, 1);
      chk("prio_ld_gnt", ld_gnt, 0);
      chk("prio_wen", tag_write_wen, 1);
      chk("prio_excl", tag_write_exclusive, 1);
      chk("prio_tag_odd", tag_odd, 1);
      chk("prio_addrOdd", tag_addrOdd, 36'h0000000F3);
      chk("prio_addrEven", tag_addrEven, 36'h0000000F3);
      chk("prio_rand", tag_write_rand, m_lfsr);
      m_lfsr = lfsr_step(m_lfsr);
      check_puke(0);
      adv;
      fill_req = 1'b0;
      smp;
      chk("turn_fill_gnt", fill_gnt, 0);
      chk("turn_ld_gnt", ld_gnt, 0);
      chk("turn_read_en", tag_read_en, 0);
      check_puke(0);
      adv;
      smp;
      chk("after_turn_ld_gnt", ld_gnt, 1);
      chk("after_turn_fill_gnt", fill_gnt, 0);
      check_puke(1);
      adv;
      ld_req = 1'b0;

      way_recent = 8'h20; #1;
      chk("recent_hi", tag_recent_in, 1);
      way_recent = 8'h00; #1;
      chk("recent_lo", tag_recent_in, 0);

      // snoop burst, one per cycle
      for (int i = 0; i < 8; i++) begin
         snp_req = 1'b1; snp_idx = 7'(i);
         smp;
         chk($sformatf("burst_rdy%0d", i), snp_rdy, 1);
         check_puke(1);
         sb.push_back(7'(i));
         adv;
      end
      snp_req = 1'b0;
      smp; check_puke(1); adv;
      smp; check_puke(1); adv;

      // fill hazard: incoming then queued snoop on the same set/bank
      snp_req = 1'b1; snp_idx = 7'h45;
      fill_req = 1'b1; fill_excl = 1'b0; fill_addr = 36'h12345600B;
      smp;
      chk("hz_incoming_fill_gnt", fill_gnt, 0);
      check_puke(1);
      sb.push_back(7'h45);
      adv;
      snp_req = 1'b0;
      smp;
      chk("hz_queued_fill_gnt", fill_gnt, 0);
      check_puke(1);
      adv;
      smp;
      chk("hz_clear_fill_gnt", fill_gnt, 1);
      chk("hz_addrEven", tag_addrEven, 36'h12345600B);
      chk("hz_excl", tag_write_exclusive, 0);
      chk("hz_rand", tag_write_rand, m_lfsr);
      m_lfsr = lfsr_step(m_lfsr);
      check_puke(0);
      adv;
      fill_req = 1'b0;
      smp;
      chk("hz_turn_fill_gnt", fill_gnt, 0);
      check_puke(0);
      adv;

      // load hazard: incoming snoop does not block, queued one does
      ld_req = 1'b1; ld_odd = 1'b1;
      snp_req = 1'b1; snp_idx = 7'h61;
      smp;
      chk("ldhz_incoming_gnt", ld_gnt, 1);
      check_puke(1);
      sb.push_back(7'h61);
      adv;
      snp_req = 1'b0;
      smp;
      chk("ldhz_queued_gnt", ld_gnt, 0);
      check_puke(1);
      adv;
      smp;
      chk("ldhz_clear_gnt", ld_gnt, 1);
      check_puke(1);
      adv;
      ld_req = 1'b0;

      // fill stream blocks pops while the queue fills
      fill_req = 1'b1; fill_addr = 36'h00000007E;
      for (int i = 0; i < 9; i++) begin
         snp_req = 1'b1; snp_idx = 7'(8'h10 + i);
         smp;
         chk($sformatf("full_fill_gnt%0d", i), fill_gnt, (i % 2 == 0) ? 1 : 0);
         chk($sformatf("full_rdy%0d", i), snp_rdy, (i < 8) ? 1 : 0);
         check_puke(0);
         if (i < 8) sb.push_back(7'(8'h10 + i));
         adv;
      end
      snp_req = 1'b0; fill_req = 1'b0; rst = 1'b1;
      smp;
      chk("full_hold_rdy", snp_rdy, 0);
      check_puke(0);
      adv;
      sb.delete();
      rst = 1'b0;
      smp;
      chk("mid_rst_busy", busy_init, 1);
      chk("mid_rst_rdy", snp_rdy, 0);
      chk("mid_rst_fill_gnt", fill_gnt, 0);
      chk("mid_rst_rand", tag_write_rand, 0);
      check_puke(0);
      repeat (64) adv;
      smp;
      chk("post_rst_busy", busy_init, 0);
      chk("post_rst_rdy", snp_rdy, 1);
      check_puke(1);
      adv;

      // LFSR sequence across back-to-back fills
      fill_req = 1'b1; fill_addr = 36'h000000001;
      for (int j = 0; j < 5; j++) begin
         smp;
         chk($sformatf("lfsr_fill_gnt%0d", j), fill_gnt, (j % 2 == 0) ? 1 : 0);
         if (j % 2 == 0) chk($sformatf("lfsr_rand%0d", j / 2), tag_write_rand, exp_rand[j / 2]);
         adv;
      end
      fill_req = 1'b0;
      adv;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
